// File: rtl/sram_controller.sv
// sram_controller: bridges 32-bit MEM-stage loads/stores onto a 16-bit
// asynchronous SRAM as two halfword phases (LO then HI), and freezes the
// pipeline through ready while an access is in flight.
module sram_controller #(
  parameter int unsigned SRAM_WAIT = 2,
  parameter int unsigned BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 17;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SRAM_WAIT - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      wdata_hi_q;
  logic             is_write_q;

  logic             req;
  logic             last;
  logic [IDX_W-1:0] req_idx;

  // Word index relative to the data-memory base; wraps modulo 2^17 words.
  assign req_idx = IDX_W'((address - 32'(BASE_ADDR)) >> 2);
  assign req     = wr_en | rd_en;
  assign last    = (wait_cnt == LAST_CNT);

  // Freeze request goes out in the request cycle itself; DONE releases for one cycle.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = ~req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Access sequencer: LO halfword phase, HI halfword phase, one-cycle DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      idx_q       <= '0;
      wdata_hi_q  <= '0;
      is_write_q  <= 1'b0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx_q      <= req_idx;
            wdata_hi_q <= write_data[31:16];
            is_write_q <= wr_en;
            wait_cnt   <= '0;
            sram_addr  <= {req_idx, 1'b0};
            sram_we_n  <= ~wr_en;
            sram_dq_oe <= wr_en;
            if (wr_en) begin
              sram_dq_out <= write_data[15:0];
            end
            state <= LO;
          end
        end
        LO: begin
          if (last) begin
            wait_cnt  <= '0;
            sram_addr <= {idx_q, 1'b1};
            if (is_write_q) begin
              sram_dq_out <= wdata_hi_q;
            end else begin
              read_data[15:0] <= sram_dq_in;
            end
            state <= HI;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        HI: begin
          if (last) begin
            wait_cnt   <= '0;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!is_write_q) begin
              read_data[31:16] <= sram_dq_in;
            end
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
